instr_encode_loader: RTL and testbench

- Streaming instruction encoder and program loader: the inverse of immediate extension. Accepts (immSrc, immediate, base instruction) descriptors and scatters the immediate into the RISC-V bit positions for that format.
- Range-checks each immediate and writes the encoded words to consecutive instruction-memory addresses.
- Sits between the debug/boot front end and the instruction memory write port; used for self-test program loading and encoder/extender round-trip checking.

---
 rtl/instr_encode_loader_if.sv | 23 ++
 rtl/instr_encode_loader.sv | 113 +++++++++++
 tb/tb_instr_encode_loader.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_encode_loader_if.sv
// instr_encode_loader_if: descriptor stream in, instruction-memory write port out.
interface instr_encode_loader_if #(
  parameter int BIT_COUNT = 32,
  parameter int ADDR_W    = 10
);
  logic                 in_valid;
  logic                 in_ready;
  logic [2:0]           ImmSrc;
  logic [BIT_COUNT-1:0] Imm;
  logic [31:0]          BaseInstr;
  logic                 mem_we;
  logic                 mem_ready;
  logic [ADDR_W-1:0]    mem_addr;
  logic [31:0]          mem_wdata;
  modport master (
    output in_valid, ImmSrc, Imm, BaseInstr, mem_ready,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );
  modport slave (
    input  in_valid, ImmSrc, Imm, BaseInstr, mem_ready,
    output in_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/instr_encode_loader.sv
// instr_encode_loader: scatters immediates into RISC-V instruction fields and streams them to memory.
module instr_encode_loader #(
  parameter int BIT_COUNT = 32,
  parameter int ADDR_W    = 10,
  parameter int CNT_W     = 10
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic [ADDR_W-1:0]      base_addr,
  input  logic [CNT_W-1:0]       count,
  instr_encode_loader_if.slave   bus,
  output logic                   busy,
  output logic                   done,
  output logic                   err,
  output logic [CNT_W-1:0]       err_index
);
  localparam int SH = $clog2(BIT_COUNT);
  localparam logic [2:0] IMM_I = 3'd0, IMM_SH = 3'd1, IMM_S = 3'd2, IMM_U = 3'd3, IMM_J = 3'd4, IMM_B = 3'd5;
  typedef enum logic [1:0] {IDLE, LOAD, DRAIN} state_t;
  state_t            state_q, state_d;
  logic [CNT_W-1:0]  count_q, count_d, idx_q, idx_d, err_index_q, err_index_d;
  logic [ADDR_W-1:0] addr_q, addr_d, mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d, fld, enc;
  logic              mem_we_q, mem_we_d, err_q, err_d, zdone_q, zdone_d, rerr, accept, wr;
  // True when v is the sign extension of its low n bits.
  function automatic logic fits(input logic [BIT_COUNT-1:0] v, input int n);
    logic signed [BIT_COUNT-1:0] t;
    t = $signed(v << (BIT_COUNT - n));
    return (t >>> (BIT_COUNT - n)) == $signed(v);
  endfunction
  always_comb begin
    fld  = '0;
    rerr = 1'b0;
    case (bus.ImmSrc)
      IMM_I:  begin fld[31:20] = bus.Imm[11:0]; rerr = !fits(bus.Imm, 12); end
      IMM_SH: begin fld[19+SH:20] = bus.Imm[SH-1:0]; rerr = |(bus.Imm >> SH); end
      IMM_S:  begin fld = {bus.Imm[11:5], 13'b0, bus.Imm[4:0], 7'b0}; rerr = !fits(bus.Imm, 12); end
      IMM_U:  begin fld = {bus.Imm[31:12], 12'b0}; rerr = (|bus.Imm[11:0]) || !fits(bus.Imm, 32); end
      IMM_J:  begin fld = {bus.Imm[20], bus.Imm[10:1], bus.Imm[11], bus.Imm[19:12], 12'b0}; rerr = !fits(bus.Imm, 21) || bus.Imm[0]; end
      IMM_B:  begin fld = {bus.Imm[12], bus.Imm[10:5], 13'b0, bus.Imm[4:1], bus.Imm[11], 7'b0}; rerr = !fits(bus.Imm, 13) || bus.Imm[0]; end
      default: rerr = 1'b1;
    endcase
    enc = bus.BaseInstr | fld;
  end
  assign wr           = mem_we_q && bus.mem_ready;
  assign bus.in_ready = (state_q == LOAD) && (!mem_we_q || bus.mem_ready);
  assign accept       = bus.in_valid && bus.in_ready;
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    idx_d       = idx_q;
    addr_d      = addr_q;
    mem_we_d    = wr ? 1'b0 : mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    err_d       = err_q;
    err_index_d = err_index_q;
    zdone_d     = 1'b0;
    if (state_q == IDLE && start) begin
      state_d = (count != '0) ? LOAD : IDLE;
      count_d = count;
      idx_d   = '0;
      addr_d  = base_addr;
      err_d   = 1'b0;
      zdone_d = (count == '0);
    end
    // A write handshake and a new accept may coincide; the accept reloads the register.
    if (accept) begin
      mem_we_d    = 1'b1;
      mem_addr_d  = addr_q;
      mem_wdata_d = enc;
      addr_d      = addr_q + ADDR_W'(1);
      idx_d       = idx_q + CNT_W'(1);
      err_d       = err_q | rerr;
      err_index_d = (rerr && !err_q) ? idx_q : err_index_q;
      state_d     = (idx_q == count_q - CNT_W'(1)) ? DRAIN : state_q;
    end
    if (state_q == DRAIN && wr) state_d = IDLE;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      count_q     <= '0;
      idx_q       <= '0;
      addr_q      <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      err_q       <= 1'b0;
      err_index_q <= '0;
      zdone_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      idx_q       <= idx_d;
      addr_q      <= addr_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      err_q       <= err_d;
      err_index_q <= err_index_d;
      zdone_q     <= zdone_d;
    end
  end
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign busy          = state_q != IDLE;
  assign done          = zdone_q || (state_q == DRAIN && wr);
  assign err           = err_q;
  assign err_index     = err_index_q;
endmodule

// File: tb/tb_instr_encode_loader.sv
// tb_instr_encode_loader: directed and randomized loads checked against an arithmetic encoder model.
module tb_instr_encode_loader;
  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0;
  logic [9:0] base_addr = '0;
  logic [9:0] count = '0;
  logic       busy, done, err;
  logic [9:0] err_index;
  instr_encode_loader_if #(.BIT_COUNT(32), .ADDR_W(10)) bus ();
  instr_encode_loader #(.BIT_COUNT(32), .ADDR_W(10), .CNT_W(10)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .base_addr(base_addr), .count(count),
    .bus(bus.slave), .busy(busy), .done(done), .err(err), .err_index(err_index)
  );
  always #5 clk = ~clk;
  int total = 0, bad = 0, mr_mode = 0, stall_sum = 0;
  logic [41:0] exp_q[$], obs_q[$];
  logic [2:0]  d_src[64];
  logic [31:0] d_imm[64], d_bi[64];
  logic [9:0]  eb, exp_eidx;
  logic        exp_err;
  always @(posedge clk) begin
    #2;
    bus.mem_ready = (mr_mode == 0) ? 1'b1 : (mr_mode == 2) ? 1'b0 : 1'($urandom_range(0, 1));
  end
  always @(negedge clk)
    if (reset_n && bus.mem_we && bus.mem_ready) obs_q.push_back({bus.mem_addr, bus.mem_wdata});
  task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, o, e);
    end
  endtask
  // Reference encoder: field placement by shift/mask, range checks as signed intervals.
  function automatic void model(input logic [2:0] s, input logic [31:0] imm, input logic [31:0] bi,
                                output logic [31:0] w, output logic e);
    int si;
    si = $signed(imm);
    w = bi;
    e = 1'b0;
    case (s)
      3'd0: begin w = bi | ((imm & 32'hFFF) << 20); e = si < -2048 || si > 2047; end
      3'd1: begin w = bi | ((imm & 32'h1F) << 20); e = imm > 32'd31; end
      3'd2: begin w = bi | (((imm >> 5) & 32'h7F) << 25) | ((imm & 32'h1F) << 7); e = si < -2048 || si > 2047; end
      3'd3: begin w = bi | (imm & 32'hFFFFF000); e = (imm & 32'hFFF) != 0; end
      3'd4: begin
        w = bi | (((imm >> 20) & 1) << 31) | (((imm >> 1) & 32'h3FF) << 21) | (((imm >> 11) & 1) << 20) | (((imm >> 12) & 32'hFF) << 12);
        e = si < -(1 << 20) || si >= (1 << 20) || imm[0];
      end
      3'd5: begin
        w = bi | (((imm >> 12) & 1) << 31) | (((imm >> 5) & 32'h3F) << 25) | (((imm >> 1) & 32'hF) << 8) | (((imm >> 11) & 1) << 7);
        e = si < -(1 << 12) || si >= (1 << 12) || imm[0];
      end
      default: e = 1'b1;
    endcase
  endfunction
  task automatic set_d(input int i, input logic [2:0] s, input logic [31:0] imm, input logic [31:0] bi);
    d_src[i] = s;
    d_imm[i] = imm;
    d_bi[i]  = bi;
  endtask
  task automatic gen_d(input int i);
    logic [2:0]  s;
    logic [31:0] imm, r;
    s = 3'($urandom_range(0, 6));
    r = $urandom;
    case (s)
      3'd0, 3'd2: imm = 32'($urandom_range(0, 4095)) - 32'd2048;
      3'd1:       imm = 32'($urandom_range(0, 31));
      3'd3:       imm = r & 32'hFFFFF000;
      3'd4:       imm = (32'($urandom_range(0, (1 << 21) - 1)) - 32'h100000) & 32'hFFFFFFFE;
      3'd5:       imm = (32'($urandom_range(0, (1 << 13) - 1)) - 32'h1000) & 32'hFFFFFFFE;
      default:    imm = r;
    endcase
    if ($urandom_range(0, 4) == 0) imm = $urandom;
    set_d(i, s, imm, 32'($urandom_range(0, 127)));
  endtask
  task automatic start_load(input logic [9:0] b, input logic [9:0] n);
    base_addr = b;
    count     = n;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start    = 1'b0;
    eb       = b;
    exp_err  = 1'b0;
    exp_eidx = '0;
    exp_q.delete();
    obs_q.delete();
  endtask
  task automatic present(input int i);
    logic [31:0] w;
    logic        e;
    model(d_src[i], d_imm[i], d_bi[i], w, e);
    exp_q.push_back({10'(eb + 10'(i)), w});
    if (e && !exp_err) begin
      exp_err  = 1'b1;
      exp_eidx = 10'(i);
    end
    bus.in_valid  = 1'b1;
    bus.ImmSrc    = d_src[i];
    bus.Imm       = d_imm[i];
    bus.BaseInstr = d_bi[i];
  endtask
  task automatic wait_acc();
    int st;
    st = 0;
    @(negedge clk);
    while (!bus.in_ready && st < 200) begin
      st++;
      @(negedge clk);
    end
    if (st >= 200) chk("accept_timeout", 64'(bus.in_ready), 64'd1);
    stall_sum += st;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask
  task automatic send(input int i);
    present(i);
    wait_acc();
  endtask
  task automatic finish_load(input string tag);
    int n;
    n = 0;
    @(negedge clk);
    while (!done && n < 200) begin
      n++;
      @(negedge clk);
    end
    chk({tag, "_done"}, 64'(done), 64'd1);
    @(posedge clk);
    #1;
    chk({tag, "_done_pulse"}, 64'(done), 64'd0);
    chk({tag, "_nwords"}, 64'(obs_q.size()), 64'(exp_q.size()));
    foreach (exp_q[k])
      if (k < obs_q.size()) chk($sformatf("%s_w%0d", tag, k), 64'(obs_q[k]), 64'(exp_q[k]));
    chk({tag, "_err"}, 64'(err), 64'(exp_err));
    if (exp_err) chk({tag, "_err_index"}, 64'(err_index), 64'(exp_eidx));
    chk({tag, "_idle"}, 64'(busy), 64'd0);
  endtask
  initial begin
    logic [9:0]  a0;
    logic [31:0] w0;
    int          n;
    bus.in_valid  = 1'b0;
    bus.ImmSrc    = '0;
    bus.Imm       = '0;
    bus.BaseInstr = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_we", 64'(bus.mem_we), 64'd0);
    chk("rst_addr", 64'(bus.mem_addr), 64'd0);
    chk("rst_wdata", 64'(bus.mem_wdata), 64'd0);
    chk("rst_eidx", 64'(err_index), 64'd0);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    set_d(0, 3'd0, 32'hFFFFFFFF, 32'h00000013);
    start_load(10'h010, 10'd1);
    send(0);
    finish_load("itype");
    if (obs_q.size() > 0) chk("itype_const", 64'(obs_q[0]), 64'({10'h010, 32'hFFF00013}));
    set_d(0, 3'd2, 32'hFFFFFFFC, 32'h00002023);
    set_d(1, 3'd5, 32'hFFFFFFFE, 32'h00000063);
    start_load(10'h020, 10'd2);
    send(0);
    send(1);
    finish_load("sb");
    if (obs_q.size() > 1) begin
      chk("stype_const", 64'(obs_q[0]), 64'({10'h020, 32'hFE002E23}));
      chk("btype_const", 64'(obs_q[1]), 64'({10'h021, 32'hFE000FE3}));
    end
    set_d(0, 3'd4, 32'h00000800, 32'h0000006F);
    set_d(1, 3'd3, 32'h12345000, 32'h00000037);
    start_load(10'h030, 10'd2);
    send(0);
    send(1);
    finish_load("ju");
    if (obs_q.size() > 1) begin
      chk("jtype_const", 64'(obs_q[0][31:0]), 64'h0010006F);
      chk("utype_const", 64'(obs_q[1][31:0]), 64'h12345037);
    end
    set_d(0, 3'd0, 32'h00000005, 32'h00000013);
    set_d(1, 3'd0, 32'h00000800, 32'h00000013);
    set_d(2, 3'd2, 32'h00000007, 32'h00002023);
    start_load(10'h040, 10'd3);
    for (int i = 0; i < 3; i++) send(i);
    finish_load("rangeerr");
    chk("rangeerr_err_const", 64'(err), 64'd1);
    chk("rangeerr_idx_const", 64'(err_index), 64'd1);
    for (int i = 0; i < 3; i++) set_d(i, 3'd0, 32'(i + 1), 32'h00000013);
    start_load(10'h050, 10'd3);
    chk("start_clears_err", 64'(err), 64'd0);
    send(0);
    present(1);
    mr_mode = 2;
    @(negedge clk);
    a0 = bus.mem_addr;
    w0 = bus.mem_wdata;
    chk("stall_in_ready0", 64'(bus.in_ready), 64'd0);
    for (int c = 1; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("stall_in_ready%0d", c), 64'(bus.in_ready), 64'd0);
      chk($sformatf("stall_we%0d", c), 64'(bus.mem_we), 64'd1);
      chk($sformatf("stall_addr%0d", c), 64'(bus.mem_addr), 64'(a0));
      chk($sformatf("stall_wdata%0d", c), 64'(bus.mem_wdata), 64'(w0));
    end
    mr_mode = 0;
    wait_acc();
    send(2);
    finish_load("stall");
    for (int i = 0; i < 8; i++) gen_d(i);
    start_load(10'h100, 10'd8);
    stall_sum = 0;
    for (int i = 0; i < 8; i++) send(i);
    chk("full_rate_stalls", 64'(stall_sum), 64'd0);
    finish_load("fullrate");
    set_d(0, 3'd1, 32'h0000001F, 32'h00001013);
    set_d(1, 3'd1, 32'h00000020, 32'h00001013);
    start_load(10'h3FF, 10'd2);
    send(0);
    send(1);
    finish_load("wrap");
    if (obs_q.size() > 1) begin
      chk("wrap_addr0", 64'(obs_q[0][41:32]), 64'h3FF);
      chk("wrap_addr1", 64'(obs_q[1][41:32]), 64'h000);
    end
    base_addr = '0;
    count     = '0;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("zero_done", 64'(done), 64'd1);
    chk("zero_busy", 64'(busy), 64'd0);
    @(posedge clk);
    #1;
    chk("zero_done_pulse", 64'(done), 64'd0);
    mr_mode = 1;
    for (int r = 0; r < 6; r++) begin
      n = $urandom_range(2, 12);
      for (int i = 0; i < n; i++) gen_d(i);
      start_load(10'($urandom), 10'(n));
      send(0);
      base_addr = 10'($urandom);
      count     = 10'd1;
      start     = 1'b1;
      for (int i = 1; i < n; i++) begin
        send(i);
        start = 1'b0;
      end
      finish_load($sformatf("rand%0d", r));
    end
    mr_mode = 2;
    for (int i = 0; i < 4; i++) gen_d(i);
    start_load(10'h200, 10'd4);
    send(0);
    present(1);
    @(negedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_we", 64'(bus.mem_we), 64'd0);
    chk("abort_in_ready", 64'(bus.in_ready), 64'd0);
    chk("abort_addr", 64'(bus.mem_addr), 64'd0);
    chk("abort_wdata", 64'(bus.mem_wdata), 64'd0);
    chk("abort_err", 64'(err), 64'd0);
    chk("abort_eidx", 64'(err_index), 64'd0);
    bus.in_valid = 1'b0;
    mr_mode = 0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("abort_no_write", 64'(obs_q.size()), 64'd0);
    chk("abort_idle_done", 64'(done), 64'd0);
    set_d(0, 3'd0, 32'h000007FF, 32'h00000093);
    start_load(10'h005, 10'd1);
    send(0);
    finish_load("after_abort");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
